data_bus_arbiter: RTL and testbench

- Shares the single data port of miriscv_ram between two masters: m0 = miriscv_core load/store unit and m1 = DMA/loader master.
- Fixed priority to m0, plus a starvation counter that forces a grant to m1.
- Routes read responses back to the issuing master through a latency-matched owner pipeline.
- Gates out-of-range accesses (addr >= RAM_SIZE) and returns an error response in place of a RAM access.

---
 rtl/data_bus_arbiter.sv | 113 +++++++++++
 tb/tb_data_bus_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_arbiter.sv
// rtl/data_bus_arbiter.sv - two-master arbiter for the RAM data port
// m0 has fixed priority; a starvation counter forces m1 through, responses follow an owner pipeline.
module data_bus_arbiter #(
    parameter int RAM_SIZE     = 256,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,
    output logic        s_req_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    input  logic [31:0] s_rdata_i
);

    logic [3:0]            starve_cnt_q, starve_cnt_d;
    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [RD_LATENCY-1:0] own_q, own_d;
    logic [RD_LATENCY-1:0] err_q, err_d;
    logic [RD_LATENCY-1:0] we_q, we_d;

    logic        m0_win, m1_win, accept, oor, rsp_v;
    logic [31:0] rsp_data;

    always_comb begin
        m1_win = !rst_i && m1_req_i && (!m0_req_i || starve_cnt_q == 4'(STARVE_LIMIT));
        m0_win = !rst_i && m0_req_i && !m1_win;
        accept = m0_win || m1_win;

        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        if (m1_win) begin
            s_we_o    = m1_we_i;
            s_be_o    = m1_be_i;
            s_addr_o  = m1_addr_i;
            s_wdata_o = m1_wdata_i;
        end else if (m0_win) begin
            s_we_o    = m0_we_i;
            s_be_o    = m0_be_i;
            s_addr_o  = m0_addr_i;
            s_wdata_o = m0_wdata_i;
        end

        // Out-of-range accesses are still granted but never reach the RAM.
        oor      = accept && (s_addr_o >= 32'(RAM_SIZE));
        s_req_o  = accept && !oor;
        m0_gnt_o = m0_win;
        m1_gnt_o = m1_win;

        if (!m1_req_i || m1_win) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != 4'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end

        vld_d = (vld_q << 1) | RD_LATENCY'(accept);
        own_d = (own_q << 1) | RD_LATENCY'(m1_win);
        err_d = (err_q << 1) | RD_LATENCY'(oor);
        we_d  = (we_q  << 1) | RD_LATENCY'(s_we_o);

        // The last stage lines up with s_rdata_i for the access it describes.
        rsp_v    = vld_q[RD_LATENCY-1];
        rsp_data = (rsp_v && !err_q[RD_LATENCY-1] && !we_q[RD_LATENCY-1]) ? s_rdata_i : '0;

        m0_rvalid_o = rsp_v && !own_q[RD_LATENCY-1];
        m1_rvalid_o = rsp_v &&  own_q[RD_LATENCY-1];
        m0_err_o    = m0_rvalid_o && err_q[RD_LATENCY-1];
        m1_err_o    = m1_rvalid_o && err_q[RD_LATENCY-1];
        m0_rdata_o  = m0_rvalid_o ? rsp_data : '0;
        m1_rdata_o  = m1_rvalid_o ? rsp_data : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt_q <= '0;
            vld_q        <= '0;
            own_q        <= '0;
            err_q        <= '0;
            we_q         <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            vld_q        <= vld_d;
            own_q        <= own_d;
            err_q        <= err_d;
            we_q         <= we_d;
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb/tb_data_bus_arbiter.sv - bench for data_bus_arbiter at read latency 1 (dut a) and 2 (dut b)
module tb_data_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic        a_m0_gnt, a_m0_rvalid, a_m0_err, a_m1_gnt, a_m1_rvalid, a_m1_err;
    logic [31:0] a_m0_rdata, a_m1_rdata;
    logic        a_s_req, a_s_we;
    logic [3:0]  a_s_be;
    logic [31:0] a_s_addr, a_s_wdata, a_s_rdata;

    logic        b_m0_gnt, b_m0_rvalid, b_m0_err, b_m1_gnt, b_m1_rvalid, b_m1_err;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic        b_s_req, b_s_we;
    logic [3:0]  b_s_be;
    logic [31:0] b_s_addr, b_s_wdata, b_s_rdata, b_pipe;

    data_bus_arbiter #(.RAM_SIZE(256), .RD_LATENCY(1), .STARVE_LIMIT(4)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(a_m0_gnt), .m0_rvalid_o(a_m0_rvalid), .m0_rdata_o(a_m0_rdata), .m0_err_o(a_m0_err),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(a_m1_gnt), .m1_rvalid_o(a_m1_rvalid), .m1_rdata_o(a_m1_rdata), .m1_err_o(a_m1_err),
        .s_req_o(a_s_req), .s_we_o(a_s_we), .s_be_o(a_s_be), .s_addr_o(a_s_addr), .s_wdata_o(a_s_wdata),
        .s_rdata_i(a_s_rdata)
    );

    data_bus_arbiter #(.RAM_SIZE(256), .RD_LATENCY(2), .STARVE_LIMIT(4)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(b_m0_gnt), .m0_rvalid_o(b_m0_rvalid), .m0_rdata_o(b_m0_rdata), .m0_err_o(b_m0_err),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(b_m1_gnt), .m1_rvalid_o(b_m1_rvalid), .m1_rdata_o(b_m1_rdata), .m1_err_o(b_m1_err),
        .s_req_o(b_s_req), .s_we_o(b_s_we), .s_be_o(b_s_be), .s_addr_o(b_s_addr), .s_wdata_o(b_s_wdata),
        .s_rdata_i(b_s_rdata)
    );

    // RAM models: word i preloads to 0x1000_0000+i (word 4 = 0xDEADBEEF); idle/write cycles return 0xA5A5A5A5.
    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];

    always @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < 64; w++) mem_a[w] <= (w == 4) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(w);
            a_s_rdata <= 32'hA5A5A5A5;
        end else begin
            if (a_s_req && a_s_we)
                for (int k = 0; k < 4; k++)
                    if (a_s_be[k]) mem_a[a_s_addr[7:2]][8*k +: 8] <= a_s_wdata[8*k +: 8];
            a_s_rdata <= (a_s_req && !a_s_we) ? mem_a[a_s_addr[7:2]] : 32'hA5A5A5A5;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < 64; w++) mem_b[w] <= (w == 4) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(w);
            b_pipe    <= 32'hA5A5A5A5;
            b_s_rdata <= 32'hA5A5A5A5;
        end else begin
            if (b_s_req && b_s_we)
                for (int k = 0; k < 4; k++)
                    if (b_s_be[k]) mem_b[b_s_addr[7:2]][8*k +: 8] <= b_s_wdata[8*k +: 8];
            b_pipe    <= (b_s_req && !b_s_we) ? mem_b[b_s_addr[7:2]] : 32'hA5A5A5A5;
            b_s_rdata <= b_pipe;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [31:0] ad0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] ad1, input logic [31:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = ad0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = ad1; m1_wdata = d1;
    endtask

    typedef struct {
        logic        m0_req;
        logic        m0_we;
        logic [31:0] m0_addr;
        logic [31:0] m0_wdata;
        logic        m1_req;
        logic        m1_we;
        logic [31:0] m1_addr;
        logic [31:0] m1_wdata;
        logic [2:0]  exp_gsr;
        logic [31:0] exp_saddr;
        logic [1:0]  exp_rv;
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t tbl [22];

    initial begin
        // exp_gsr = {m0_gnt, m1_gnt, s_req}; exp_rv/exp_err = {m0, m1}; responses belong to the previous row
        tbl[0]  = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        3'b000, 32'h0,   2'b00, 32'h0,        32'h0,        2'b00};
        tbl[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        3'b101, 32'h10,  2'b00, 32'h0,        32'h0,        2'b00};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        3'b000, 32'h0,   2'b10, 32'hDEADBEEF, 32'h0,        2'b00};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h20,  32'h0,        3'b011, 32'h20,  2'b00, 32'h0,        32'h0,        2'b00};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        3'b000, 32'h0,   2'b01, 32'h0,        32'h10000008, 2'b00};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h4,   32'h0,        3'b101, 32'h0,   2'b00, 32'h0,        32'h0,        2'b00};
        for (int i = 6; i <= 8; i++)
            tbl[i] = '{1'b1, 1'b0, 32'h0, 32'h0,       1'b1, 1'b0, 32'h4,   32'h0,        3'b101, 32'h0,   2'b10, 32'h10000000, 32'h0,        2'b00};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h4,   32'h0,        3'b011, 32'h4,   2'b10, 32'h10000000, 32'h0,        2'b00};
        tbl[10] = '{1'b1, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h4,   32'h0,        3'b101, 32'h0,   2'b01, 32'h0,        32'h10000001, 2'b00};
        for (int i = 11; i <= 13; i++)
            tbl[i] = '{1'b1, 1'b0, 32'h0, 32'h0,       1'b1, 1'b0, 32'h4,   32'h0,        3'b101, 32'h0,   2'b10, 32'h10000000, 32'h0,        2'b00};
        tbl[14] = '{1'b1, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h4,   32'h0,        3'b011, 32'h4,   2'b10, 32'h10000000, 32'h0,        2'b00};
        tbl[15] = '{1'b1, 1'b1, 32'h8,   32'h12345678, 1'b0, 1'b0, 32'h0,   32'h0,        3'b101, 32'h8,   2'b01, 32'h0,        32'h10000001, 2'b00};
        tbl[16] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 32'h100, 32'hFFFFFFFF, 3'b010, 32'h100, 2'b10, 32'h0,        32'h0,        2'b00};
        tbl[17] = '{1'b1, 1'b0, 32'h8,   32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        3'b101, 32'h8,   2'b01, 32'h0,        32'h0,        2'b01};
        tbl[18] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h0,   32'h0,        3'b011, 32'h0,   2'b10, 32'h12345678, 32'h0,        2'b00};
        tbl[19] = '{1'b1, 1'b0, 32'h200, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        3'b100, 32'h200, 2'b01, 32'h0,        32'h10000000, 2'b00};
        tbl[20] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        3'b000, 32'h0,   2'b10, 32'h0,        32'h0,        2'b10};
        tbl[21] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        3'b000, 32'h0,   2'b00, 32'h0,        32'h0,        2'b00};

        m0_be = 4'hF;
        m1_be = 4'hF;
        rst   = 1'b1;
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
        #2;
        chk("reset a gnt/sreq", {29'd0, a_m0_gnt, a_m1_gnt, a_s_req}, 32'd0);
        chk("reset b gnt/sreq", {29'd0, b_m0_gnt, b_m1_gnt, b_s_req}, 32'd0);
        chk("reset a rvalid/err", {28'd0, a_m0_rvalid, a_m1_rvalid, a_m0_err, a_m1_err}, 32'd0);
        chk("reset a rdata", a_m0_rdata | a_m1_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        for (int i = 0; i < 22; i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i].m0_req, tbl[i].m0_we, tbl[i].m0_addr, tbl[i].m0_wdata,
                  tbl[i].m1_req, tbl[i].m1_we, tbl[i].m1_addr, tbl[i].m1_wdata);
            @(negedge clk);
            chk($sformatf("row%0d gnt/sreq", i), {29'd0, a_m0_gnt, a_m1_gnt, a_s_req}, {29'd0, tbl[i].exp_gsr});
            chk($sformatf("row%0d s_addr", i), a_s_addr, tbl[i].exp_saddr);
            chk($sformatf("row%0d rvalid", i), {30'd0, a_m0_rvalid, a_m1_rvalid}, {30'd0, tbl[i].exp_rv});
            chk($sformatf("row%0d m0_rdata", i), a_m0_rdata, tbl[i].exp_rd0);
            chk($sformatf("row%0d m1_rdata", i), a_m1_rdata, tbl[i].exp_rd1);
            chk($sformatf("row%0d err", i), {30'd0, a_m0_err, a_m1_err}, {30'd0, tbl[i].exp_err});
        end

        // Reset while a read is in flight: the response must never appear.
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("midrst accept", {30'd0, a_m0_gnt, b_m0_gnt}, 32'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst a outputs", {26'd0, a_m0_gnt, a_m1_gnt, a_s_req, a_m0_rvalid, a_m1_rvalid, a_m0_err}, 32'd0);
        chk("midrst b outputs", {27'd0, b_m0_gnt, b_m1_gnt, b_s_req, b_m0_rvalid, b_m1_rvalid}, 32'd0);
        chk("midrst a rdata", a_m0_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("postrst c%0d rvalid", c), {28'd0, a_m0_rvalid, a_m1_rvalid, b_m0_rvalid, b_m1_rvalid}, 32'd0);
            @(posedge clk);
            #1;
        end

        // Latency-2 interleave on dut b: m0 rd 0x0, m1 rd 0x4, m0 wr 0x8, m0 rd 0x8.
        begin
            logic [1:0]  exp_g  [7];
            logic [1:0]  exp_rv [7];
            logic [31:0] exp_r0 [7];
            logic [31:0] exp_r1 [7];
            exp_g  = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
            exp_rv = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00};
            exp_r0 = '{32'h0, 32'h0, 32'h10000000, 32'h0, 32'h0, 32'hCAFEF00D, 32'h0};
            exp_r1 = '{32'h0, 32'h0, 32'h0, 32'h10000001, 32'h0, 32'h0, 32'h0};
            for (int c = 0; c < 7; c++) begin
                @(posedge clk);
                #1;
                case (c)
                    0:       drive(1'b1, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 32'h0, 32'h0);
                    1:       drive(1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'h4, 32'h0);
                    2:       drive(1'b1, 1'b1, 32'h8, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 32'h0);
                    3:       drive(1'b1, 1'b0, 32'h8, 32'h0,        1'b0, 1'b0, 32'h0, 32'h0);
                    default: drive(1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 32'h0, 32'h0);
                endcase
                @(negedge clk);
                chk($sformatf("lat2 c%0d gnt", c), {30'd0, b_m0_gnt, b_m1_gnt}, {30'd0, exp_g[c]});
                chk($sformatf("lat2 c%0d rvalid", c), {30'd0, b_m0_rvalid, b_m1_rvalid}, {30'd0, exp_rv[c]});
                chk($sformatf("lat2 c%0d m0_rdata", c), b_m0_rdata, exp_r0[c]);
                chk($sformatf("lat2 c%0d m1_rdata", c), b_m1_rdata, exp_r1[c]);
                chk($sformatf("lat2 c%0d err", c), {30'd0, b_m0_err, b_m1_err}, 32'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
